nibble_serial_add_ctrl: RTL

//  Sequencer that drives one shared 4-bit ripple-carry adder nibble by nibble.
//  It produces WIDTH-bit add/subtract results over WIDTH/4 clock cycles.
//  It sits between a requesting datapath (start/done handshake) and the adder.
//  It trades latency for area: one 4-bit adder instead of a WIDTH-bit one.

---
 rtl/adder_pkg.sv | 10 +
 rtl/nibble_adder4.sv | 23 ++
 rtl/nibble_serial_add_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the nibble-serial adder: nibble width and FSM encodings.
package adder_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_adder4.sv
// Purely combinational 4-bit ripple-carry adder shared by every nibble step.
module nibble_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c4
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    c4 = c[4];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that computes WIDTH-bit add/subtract through one 4-bit adder,
// one nibble per clock, least significant nibble first.
module nibble_serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       fsm_state
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);
  localparam int MSB   = WIDTH - 1;

  // Handshake: start is accepted on a rising edge only while in IDLE or DONE;
  // done is a one-cycle pulse during which sum/cout/ovf are valid. Start
  // seen during RUN is dropped, not queued.

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [NIB_W-1:0] nib_s;
  logic             nib_c4;
  logic             last_nib;

  nibble_adder4 u_adder (
    .a   (a_r[idx*NIB_W +: NIB_W]),
    .b   (b_r[idx*NIB_W +: NIB_W]),
    .cin (carry),
    .s   (nib_s),
    .c4  (nib_c4)
  );

  assign last_nib  = (idx == IDX_W'(NIB - 1));
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b once here, inject the +1 as carry-in.
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum[idx*NIB_W +: NIB_W] <= nib_s;
          carry                   <= nib_c4;
          if (last_nib) begin
            idx   <= '0;
            cout  <= nib_c4;
            // nib_s MSB is the new sum MSB being written on this edge.
            ovf   <= (a_r[MSB] == b_r[MSB]) & (nib_s[NIB_W-1] != a_r[MSB]);
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
